// File: rtl/sja_bus_responder.sv
// SJA1000 Intel-mode multiplexed bus slave model with a byte register file,
// user-side register port and IR/IER interrupt pair driving int_n.
//
// state | meaning
// IDLE  | waiting for a qualified read or write strobe
// READ  | driving ad_out with data fetched at entry
// WRITE | capturing write data until the strobe releases
// ERR   | rd and wr strobes both low; wait for both to release
module sja_bus_responder #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        ad_in,
  input  logic              ale,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  output logic [7:0]        ad_out,
  output logic              ad_oe,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [7:0]        usr_wdata,
  input  logic              usr_we,
  output logic [7:0]        usr_rdata,
  output logic              usr_collision,
  input  logic [7:0]        irq_set,
  output logic              int_n,
  output logic              bus_wr_pulse
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IR_IDX  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] IER_IDX = ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

  state_t      state;
  logic [7:0]  ad_sync  [SYNC_STAGES];
  logic [3:0]  ctl_sync [SYNC_STAGES];
  logic [7:0]  regs     [DEPTH];
  logic [7:0]  ad_s;
  logic        ale_s, cs_s, rd_s, wr_s;
  logic        rd_d, wr_d;
  logic        rd_fall, wr_fall;
  logic [7:0]  addr_q, wdata_q;
  logic        addr_ok;
  logic [ADDR_W-1:0] bus_idx;
  logic [7:0]  rd_data, ir, ier, ir_next;
  logic        bus_commit, ir_clear, usr_ir_wr;

  // Control synchronizer word is {ale, cs_n, rd_n, wr_n}; resets to bus idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ad_sync[i]  <= 8'h00;
        ctl_sync[i] <= 4'b0111;
      end
    end else begin
      ad_sync[0]  <= ad_in;
      ctl_sync[0] <= {ale, cs_n, rd_n, wr_n};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ad_sync[i]  <= ad_sync[i-1];
        ctl_sync[i] <= ctl_sync[i-1];
      end
    end
  end

  assign ad_s  = ad_sync[SYNC_STAGES-1];
  assign ale_s = ctl_sync[SYNC_STAGES-1][3];
  assign cs_s  = ctl_sync[SYNC_STAGES-1][2];
  assign rd_s  = ctl_sync[SYNC_STAGES-1][1];
  assign wr_s  = ctl_sync[SYNC_STAGES-1][0];

  assign rd_fall = rd_d & ~rd_s;
  assign wr_fall = wr_d & ~wr_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d    <= 1'b1;
      wr_d    <= 1'b1;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      rd_d <= rd_s;
      wr_d <= wr_s;
      if (ale_s) addr_q <= ad_s;
      if (!wr_s) wdata_q <= ad_s;
    end
  end

  assign addr_ok   = ((addr_q >> ADDR_W) == 8'h00);
  assign bus_idx   = addr_q[ADDR_W-1:0];
  assign rd_data   = addr_ok ? regs[bus_idx] : 8'h00;
  assign ir        = regs[IR_IDX];
  assign ier       = regs[IER_IDX];
  assign usr_rdata = regs[usr_addr];

  assign bus_commit = (state == WRITE) && !cs_s && wr_s && addr_ok && (bus_idx != IR_IDX);
  assign ir_clear   = (state == READ) && !cs_s && rd_s && (addr_q == 8'd3);
  assign usr_ir_wr  = usr_we && !bus_commit && (usr_addr == IR_IDX);

  // Set sources win over the read-clear per bit.
  assign ir_next = (ir_clear ? 8'h00 : ir) | irq_set | (usr_ir_wr ? usr_wdata : 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      if (bus_commit) regs[bus_idx] <= wdata_q;
      else if (usr_we && (usr_addr != IR_IDX)) regs[usr_addr] <= usr_wdata;
      regs[IR_IDX] <= ir_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ad_out        <= 8'h00;
      ad_oe         <= 1'b0;
      bus_wr_pulse  <= 1'b0;
      usr_collision <= 1'b0;
      int_n         <= 1'b1;
    end else begin
      bus_wr_pulse  <= bus_commit;
      usr_collision <= bus_commit & usr_we;
      int_n         <= ~|(ir & ier);
      case (state)
        IDLE: begin
          if (!rd_s && !wr_s) begin
            state <= ERR;
          end else if (!cs_s && rd_fall && wr_s) begin
            state  <= READ;
            ad_out <= rd_data;
            ad_oe  <= 1'b1;
          end else if (!cs_s && wr_fall && rd_s) begin
            state <= WRITE;
          end
        end
        READ: begin
          if (rd_s || cs_s) begin
            state <= IDLE;
            ad_oe <= 1'b0;
          end
        end
        WRITE: begin
          if (cs_s || wr_s) state <= IDLE;
        end
        ERR: begin
          ad_oe <= 1'b0;
          if (rd_s && wr_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sja_bus_responder.sv
// Directed bench for sja_bus_responder: bus read/write timing, register map,
// interrupt set/clear, collisions, strobe error and async reset.
`timescale 1ns/1ps
module tb_sja_bus_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ad_in;
  logic       ale, cs_n, rd_n, wr_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [4:0] usr_addr;
  logic [7:0] usr_wdata;
  logic       usr_we;
  logic [7:0] usr_rdata;
  logic       usr_collision;
  logic [7:0] irq_set;
  logic       int_n;
  logic       bus_wr_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int coll_cnt = 0;

  sja_bus_responder #(.ADDR_W(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .ad_in(ad_in), .ale(ale), .cs_n(cs_n),
    .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out), .ad_oe(ad_oe),
    .usr_addr(usr_addr), .usr_wdata(usr_wdata), .usr_we(usr_we),
    .usr_rdata(usr_rdata), .usr_collision(usr_collision), .irq_set(irq_set),
    .int_n(int_n), .bus_wr_pulse(bus_wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_wr_pulse === 1'b1) pulse_cnt++;
    if (usr_collision === 1'b1) coll_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [7:0] exp);
    usr_addr = a;
    #0.1;
    chk(tag, usr_rdata, exp);
  endtask

  task automatic set_addr(input logic [7:0] a);
    @(posedge clk); #2 ad_in = a; ale = 1'b1;
    repeat (3) @(posedge clk);
    #2 ale = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                           input bit tchk, input logic [7:0] old,
                           input bit inject, input logic [7:0] udata);
    set_addr(a);
    ad_in = d; cs_n = 1'b0;
    if (tchk || inject) usr_addr = a[4:0];
    repeat (4) @(posedge clk);
    #2 wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (tchk) chk("wr_before_commit", usr_rdata, old);
    if (inject) begin
      usr_wdata = udata; usr_we = 1'b1;
    end
    @(posedge clk); #1;
    usr_we = 1'b0;
    if (tchk) begin
      chk("wr_commit_edge", usr_rdata, d);
      chk("wr_pulse_edge", 8'(bus_wr_pulse), 8'd1);
    end
    if (inject) begin
      chk("coll_reg", usr_rdata, d);
      chk("coll_pulse_hi", 8'(usr_collision), 8'd1);
    end
    @(posedge clk); #1;
    if (inject) chk("coll_pulse_lo", 8'(usr_collision), 8'd0);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp,
                          input bit abort, input logic [7:0] irq_clr);
    set_addr(a);
    ad_in = 8'hEE; cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rd_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rd_oe_edge2", 8'(ad_oe), 8'd0);
    @(posedge clk); #1;
    chk("rd_oe_edge3", 8'(ad_oe), 8'd1);
    chk("rd_data", ad_out, exp);
    repeat (3) @(posedge clk); #1;
    chk("rd_data_hold", ad_out, exp);
    #1;
    if (abort) cs_n = 1'b1; else rd_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rel_oe_edge2", 8'(ad_oe), 8'd1);
    irq_set = irq_clr;
    @(posedge clk); #1;
    irq_set = 8'h00;
    chk("rel_oe_edge3", 8'(ad_oe), 8'd0);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    ad_in = 8'h00; ale = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    usr_addr = 5'd0; usr_wdata = 8'h00; usr_we = 1'b0; irq_set = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ad_oe", 8'(ad_oe), 8'd0);
    chk("rst_ad_out", ad_out, 8'h00);
    chk("rst_int_n", 8'(int_n), 8'd1);
    chk("rst_pulse", 8'(bus_wr_pulse), 8'd0);
    chk("rst_coll", 8'(usr_collision), 8'd0);
    peek("rst_reg5", 5'd5, 8'h00);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write then read
    bus_write(8'h05, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h00);
    chk("wr05_pulses", 8'(pulse_cnt), 8'd1);
    bus_read(8'h05, 8'hA5, 1'b0, 8'h00);

    // Out of range: preload reg0 so an undecoded 0x80 would alias onto it
    @(posedge clk); #2 usr_addr = 5'd0; usr_wdata = 8'h5A; usr_we = 1'b1;
    @(posedge clk); #2 usr_we = 1'b0;
    peek("usr_wr0", 5'd0, 8'h5A);
    bus_write(8'h80, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("oor_no_pulse", 8'(pulse_cnt), 8'd1);
    peek("oor_reg0", 5'd0, 8'h5A);
    bus_read(8'h80, 8'h00, 1'b0, 8'h00);

    // IR is read-only from the bus
    bus_write(8'h03, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ir_wr_no_pulse", 8'(pulse_cnt), 8'd1);
    peek("ir_wr_ignored", 5'd3, 8'h00);

    // IER = 0x01, then set IR bit 0
    bus_write(8'h04, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ier_pulses", 8'(pulse_cnt), 8'd2);
    peek("ier_val", 5'd4, 8'h01);
    chk("int_idle", 8'(int_n), 8'd1);
    @(posedge clk); #2 irq_set = 8'h01;
    @(posedge clk); #1 irq_set = 8'h00;
    peek("ir_set", 5'd3, 8'h01);
    chk("int_lag", 8'(int_n), 8'd1);
    @(posedge clk); #1;
    chk("int_asserted", 8'(int_n), 8'd0);

    // Read of IR clears it on rd release
    bus_read(8'h03, 8'h01, 1'b0, 8'h00);
    peek("ir_cleared", 5'd3, 8'h00);
    chk("int_released", 8'(int_n), 8'd1);

    // Set in the clear cycle wins
    @(posedge clk); #2 irq_set = 8'h01;
    @(posedge clk); #1 irq_set = 8'h00;
    @(posedge clk); #1;
    chk("int_reasserted", 8'(int_n), 8'd0);
    bus_read(8'h03, 8'h01, 1'b0, 8'h01);
    peek("ir_set_wins", 5'd3, 8'h01);
    chk("int_still_low", 8'(int_n), 8'd0);

    // cs abort does not clear IR
    bus_read(8'h03, 8'h01, 1'b1, 8'h00);
    peek("ir_abort_kept", 5'd3, 8'h01);

    // User write to IR ORs in
    @(posedge clk); #2 usr_addr = 5'd3; usr_wdata = 8'h80; usr_we = 1'b1;
    @(posedge clk); #2 usr_we = 1'b0;
    peek("ir_usr_or", 5'd3, 8'h81);

    // Collision: bus wins
    bus_write(8'h07, 8'h44, 1'b0, 8'h00, 1'b1, 8'h33);
    chk("coll_pulses", 8'(pulse_cnt), 8'd3);
    chk("coll_count", 8'(coll_cnt), 8'd1);
    peek("coll_final", 5'd7, 8'h44);

    // Strobe error: both low, no drive, no commit
    set_addr(8'h09);
    ad_in = 8'h77; cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rd_n = 1'b0; wr_n = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("err_oe", 8'(ad_oe), 8'd0);
    wr_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("err_oe_wr_rel", 8'(ad_oe), 8'd0);
    rd_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    cs_n = 1'b1;
    chk("err_no_pulse", 8'(pulse_cnt), 8'd3);
    peek("err_no_commit", 5'd9, 8'h00);
    repeat (3) @(posedge clk);

    // Async reset during a read
    set_addr(8'h05);
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rd_n = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("pre_rst_oe", 8'(ad_oe), 8'd1);
    chk("pre_rst_data", ad_out, 8'hA5);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_oe", 8'(ad_oe), 8'd0);
    chk("rst_mid_out", ad_out, 8'h00);
    chk("rst_mid_int", 8'(int_n), 8'd1);
    peek("rst_mid_reg5", 5'd5, 8'h00);
    peek("rst_mid_ir", 5'd3, 8'h00);
    peek("rst_mid_reg7", 5'd7, 8'h00);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_oe", 8'(ad_oe), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sja_bus_responder.md
# sja_bus_responder

Bus-side slave model of the SJA1000 Intel-mode multiplexed parallel interface (AD[7:0], ALE, CS_n, RD_n, WR_n). It latches the address on ALE, returns register data on RD_n, and commits data on WR_n into an internal byte register file. It also provides a user-side register port and an interrupt register/interrupt-enable pair that drive `int_n`. It stands in for the controller chip in system simulation and in loopback FPGA builds against the existing bus master.

## Interface
- `ADDR_W`, default 5: register file address width, giving 2^ADDR_W bytes.
- `SYNC_STAGES`, default 2: synchronizer depth on all bus inputs (≥2).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ad_in`  in  8  multiplexed address/data from the master.
- `ale`  in  1  address latch enable, active high.
- `cs_n`  in  1  chip select, active low.
- `rd_n`  in  1  read strobe, active low.
- `wr_n`  in  1  write strobe, active low.
- `ad_out`  out  8  read data toward the master.
- `ad_oe`  out  1  tristate enable for `ad_out`.
- `usr_addr`  in  ADDR_W  user-port address.
- `usr_wdata`  in  8  user-port write data.
- `usr_we`  in  1  user-port write strobe, one cycle.
- `usr_rdata`  out  8  combinational read of `reg[usr_addr]`.
- `usr_collision`  out  1  one-cycle pulse when a user write is dropped.
- `irq_set`  in  8  per-bit set pulses into the interrupt register (IR).
- `int_n`  out  1  interrupt output, active low.
- `bus_wr_pulse`  out  1  one-cycle pulse on every committed bus write.

## Operation
- **Input synchronization:** `ad_in`, `ale`, `cs_n`, `rd_n` and `wr_n` pass through SYNC_STAGES flops. All decoding uses the synchronized copies (`*_s`), so bus and data paths stay aligned.
- **Address latch:** `addr_q` ← `ad_s` every cycle that `ale_s` = 1, then holds.
  - An address with bits [7:ADDR_W] ≠ 0 is out of range.
  - Out-of-range reads return 0x00. Out-of-range writes are ignored.
- **FSM states:** IDLE, READ, WRITE, ERR.
- **IDLE:**
  - `cs_s`=0 & `rd_s` falling & `wr_s`=1 → READ.
  - `cs_s`=0 & `wr_s` falling & `rd_s`=1 → WRITE.
  - `rd_s`=0 & `wr_s`=0 → ERR.
- **READ:**
  - On entry, `ad_out` ← mapped read of `addr_q` and `ad_oe` ← 1. `ad_out` holds for the whole strobe and is not refetched.
  - Exit to IDLE with `ad_oe` ← 0 when `rd_s` rises or `cs_s` rises.
  - IR is cleared only when the exit is caused by `rd_s` rising with `cs_s`=0 and `addr_q`=3. A `cs_s` abort does not clear IR.
- **WRITE:**
  - `wdata_q` ← `ad_s` every cycle that `wr_s` = 0.
  - On `wr_s` rising with `cs_s`=0: commit `reg[addr_q]` ← `wdata_q`, pulse `bus_wr_pulse`, go to IDLE.
  - On `cs_s` rising first: go to IDLE with no commit.
- **ERR:** `ad_oe`=0 and no commit. Returns to IDLE once `rd_s`=1 and `wr_s`=1.
- **Register map:**
  - Address 3 = IR: read-only from the bus; bus writes ignored without a pulse. Bits set by `irq_set`.
  - Address 4 = IER: read/write.
  - All other in-range addresses: plain read/write bytes.
  - Same-cycle IR clear and `irq_set`: the set wins per bit.
- **User port:**
  - A write takes effect at the next clk edge. A user write to address 3 ORs into IR.
  - If a bus commit and `usr_we` occur in the same cycle, the bus wins (regardless of address), the user write is dropped and `usr_collision` pulses.
- **Interrupt:** `int_n` = ~|(IR & IER), registered.

## Timing
- **Reset values:**
  - FSM = IDLE; all registers 0x00; `ad_out`=0x00.
  - `ad_oe`=0, `usr_collision`=0, `bus_wr_pulse`=0, `int_n`=1.
  - Synchronizers reset to the bus-idle level (`ale`=0, strobes=1, `ad`=0x00).
- **Read latency:** `ad_oe`/`ad_out` become valid SYNC_STAGES+1 clk edges after the `rd_n` pin falls. With the default of 2 this is edge 3, one edge before the master samples (edge 4).
- **Release:** `ad_oe` drops SYNC_STAGES+1 edges after `rd_n` or `cs_n` rises.
- **Write commit:** the register updates SYNC_STAGES+1 edges after the `wr_n` pin rises. `bus_wr_pulse` is high during the cycle following the commit edge.
- **Interrupt:** `int_n` follows an IR/IER change by one cycle.
- **Async reset mid-transaction:** `ad_oe` drops immediately and nothing is committed.

## Test plan
- **Write then read:** bus-write addr 0x05 data 0xA5, then bus-read 0x05 → `ad_out`=0xA5 with `ad_oe` high before the 4th edge after `rd_n` falls; `bus_wr_pulse` seen once.
- **Out-of-range address:** write 0x80 data 0x11 → no pulse, no change; read 0x80 → 0x00.
- **Interrupt set and clear:** `irq_set`=0x01 with IER=0x01 → `int_n`=0 next cycle. Bus read of addr 3 returns 0x01, IR clears after `rd_n` rises, `int_n`=1. Repeat with `irq_set`=0x01 in the clear cycle → IR stays 0x01.
- **Aborted read:** raise `cs_n` mid-read of addr 3 → `ad_oe` drops, IR not cleared.
- **Collision:** `usr_we` to addr 7 (0x33) in the bus-commit cycle of a write to addr 7 (0x44) → reg=0x44, `usr_collision` pulses once.
- **Strobe error and reset:** `rd_n` and `wr_n` low together → ERR, `ad_oe`=0, no commit. Assert `reset_n` during a READ → `ad_oe`=0 at once and all registers 0x00.
